shift_rx: RTL and testbench
===========================

# shift_rx

Serial-to-parallel frame receiver: the receiving end of the serial link driven by the team's 4-bit universal shift register operating in shift-left or shift-right mode. It collects WIDTH serial bits, qualified by an enable strobe, into a shift register, assembles them MSB-first or LSB-first, and presents the completed word on a single-entry output buffer with a valid/ready handshake. Overrun is detected when a frame completes while the buffer is still full.

## Interface
- WIDTH, 4, frame/word length in bits; legal range 2..16.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; clears all state.
- start  input  1  frame-start pulse.
- sen  input  1  serial bit strobe; sin is sampled on cycles where sen=1.
- sin  input  1  serial data.
- dir  input  1  bit order. 0 = MSB-first (matches shift-left transmit); 1 = LSB-first (matches shift-right transmit). Sampled only with start.
- out  output  WIDTH  received word (output buffer).
- out_valid  output  1  out holds an unconsumed word.
- out_ready  input  1  consumer accepts the word when out_valid=1.
- busy  output  1  frame in progress (state SHIFT).
- overrun  output  1  sticky: a completed frame was dropped.
- ovr_clr  input  1  synchronous clear of overrun.

## Operation
- Reset (reset=0, asynchronous): state=IDLE, shift register=0, bit counter=0, dir_r=0, out=0, out_valid=0, busy=0, overrun=0.
- **IDLE**
  - start=1: latch dir into dir_r, clear shift register and counter, go to SHIFT. No bit is captured in this cycle, even if sen=1.
  - sen is ignored.
- **SHIFT** (busy=1)
  - Each cycle with sen=1 captures sin and increments the counter. Cycles with sen=0 hold all state; gaps of any length are legal.
  - dir_r=0 captures as sr <= {sr[WIDTH-2:0], sin}. The first bit received ends in out[WIDTH-1].
  - dir_r=1 captures as sr <= {sin, sr[WIDTH-1:1]}. The first bit received ends in out[0].
  - On the capture of bit WIDTH, the frame is complete. The assembled word (including that bit) is offered to the output buffer and the state returns to IDLE.
  - start=1 in SHIFT aborts the frame: partial bits are discarded, dir is relatched, the counter is cleared and the state stays in SHIFT. No bit is captured that cycle.
- **Output buffer**
  - The handshake completes on a cycle where out_valid=1 and out_ready=1.
  - Frame completes with buffer empty: out is loaded and out_valid goes to 1.
  - Frame completes with buffer full and a handshake in the same cycle: out is loaded with the new word and out_valid stays 1.
  - Frame completes with buffer full and no handshake: the new word is dropped, out and out_valid are unchanged, and overrun is set to 1.
  - A handshake with no completing frame clears out_valid. out keeps its last value.
  - overrun stays set until ovr_clr=1 or reset. If ovr_clr=1 and a new overrun occur in the same cycle, overrun stays 1 (set wins).
- Counter width is $clog2(WIDTH+1). The counter never exceeds WIDTH and is cleared on completion.

## Timing
- Latency: out and out_valid update on the same rising edge that samples bit WIDTH.
- Minimum frame: 1 start cycle plus WIDTH consecutive sen cycles. The next start may occur on the cycle immediately after completion, giving a back-to-back frame period of WIDTH+1 cycles.
- out_ready is not registered. out_valid may drop on the edge after the handshake.
- busy rises on the edge after start and falls on the completion edge.
- reset asserted mid-frame immediately forces all outputs to their reset values. The partial frame is lost.

## Test plan
- MSB-first, WIDTH=4: start with dir=0, then bits 1,0,1,1 with sen=1 on consecutive cycles, out_ready=0. Required: out=4'b1011 and out_valid=1 on the 4th capture edge; busy=0 afterwards.
- LSB-first: start with dir=1, then bits 1,0,1,1 with sen=0 gaps inserted between bits. Required: out=4'b1101; out_valid rises only after the 4th qualified bit.
- Overrun: receive 4'b1011 and hold out_ready=0, then receive 4'b0110. Required: out stays 4'b1011 and overrun=1. Pulse ovr_clr. Required: overrun=0.
- Simultaneous event: out_valid=1 holding 4'b1011; assert out_ready on the same cycle that 4'b0110 completes. Required: out=4'b0110, out_valid stays 1, overrun stays 0.
- Abort and reset: send 2 bits, re-assert start, then send 1,1,0,0 MSB-first. Required: out=4'b1100. Then send 2 bits of a new frame and pulse reset=0. Required: out=0, out_valid=0, busy=0, overrun=0 immediately.
- Idle noise: sen=1 with random sin while in IDLE for 10 cycles. Required: no change to out or out_valid, and busy stays 0.

Source files
------------

// File: rtl/shift_rx.sv
// Serial-to-parallel frame receiver: collects WIDTH strobed serial bits MSB- or LSB-first
// and presents each completed word on a single-entry valid/ready buffer with sticky overrun.
module shift_rx #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sen,
  input  logic             sin,
  input  logic             dir,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             ovr_clr
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic [WIDTH-1:0] sr_cap;
  logic             frame_done;
  logic             handshake;
  logic             ovr_set;

  // Word as it would look after capturing the current sin, in the latched bit order.
  always_comb begin
    if (dir_q) begin
      sr_cap = {sin, sr_q[WIDTH-1:1]};
    end else begin
      sr_cap = {sr_q[WIDTH-2:0], sin};
    end
  end

  assign handshake = valid_q & out_ready;

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    frame_done = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StShift;
          dir_d   = dir;
          sr_d    = '0;
          cnt_d   = '0;
        end
      end
      StShift: begin
        // start restarts the frame and wins over a coincident strobe
        if (start) begin
          dir_d = dir;
          sr_d  = '0;
          cnt_d = '0;
        end else if (sen) begin
          sr_d = sr_cap;
          if (cnt_q == LastCnt) begin
            frame_done = 1'b1;
            cnt_d      = '0;
            state_d    = StIdle;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    ovr_set = 1'b0;

    if (frame_done) begin
      // A same-cycle handshake frees the slot for the new word.
      if (!valid_q || handshake) begin
        out_d   = sr_cap;
        valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (handshake) begin
      valid_d = 1'b0;
    end

    ovr_d = ovr_set | (ovr_q & ~ovr_clr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      sr_q    <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign busy      = (state_q == StShift);
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_shift_rx.sv
// Randomized bench for shift_rx: a bit-queue reference model predicts every cycle and a
// scoreboard queue of accepted words is drained by a monitor on each handshake.
module tb_shift_rx;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start, sen, sin, dir, out_ready, ovr_clr;
  logic [W-1:0] out;
  logic         out_valid, busy, overrun;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_q[$];

  // Reference model state: what the receiver should look like after the next edge.
  bit           m_busy, m_dir, m_full, m_ovr;
  logic [W-1:0] m_out;
  bit           m_bits[$];

  shift_rx #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sen      (sen),
    .sin      (sin),
    .dir      (dir),
    .out      (out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .overrun  (overrun),
    .ovr_clr  (ovr_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: each handshake must consume the oldest accepted word.
  always @(negedge clk) begin
    if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_word: got %h expected nothing (queue empty) at %0t", out, $time);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (out !== e) begin
          n_fail++;
          $display("FAIL sb_word: got %h expected %h at %0t", out, e, $time);
        end
      end
    end
  end

  function automatic bit rnd_rdy(input int mode);
    if (mode == 2) return bit'($urandom_range(0, 1));
    return bit'(mode);
  endfunction

  function automatic logic [W-1:0] assemble(input bit d);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < int'(W); i++) begin
      if (d) w[i] = m_bits[i];
      else   w[W-1-i] = m_bits[i];
    end
    return w;
  endfunction

  model_reset_clear: assert property (@(posedge clk) 1'b1);

  task automatic model_reset();
    m_busy = 0; m_dir = 0; m_full = 0; m_ovr = 0; m_out = '0;
    m_bits.delete();
    exp_q.delete();
  endtask

  // One clock cycle: inputs applied at posedge+1, outputs compared at the following posedge+1.
  task automatic cycle(input bit st, input bit se, input bit si, input bit di, input bit rdy,
                       input bit clr);
    bit hs, accepted, set_ovr;
    hs = m_full && rdy;
    accepted = 0;
    set_ovr = 0;
    if (st) begin
      m_busy = 1;
      m_dir  = di;
      m_bits.delete();
    end else if (m_busy && se) begin
      m_bits.push_back(si);
      if (m_bits.size() == int'(W)) begin
        logic [W-1:0] word;
        word = assemble(m_dir);
        m_busy = 0;
        m_bits.delete();
        if (!m_full || hs) begin
          m_out = word;
          exp_q.push_back(word);
          m_full = 1;
          accepted = 1;
        end else begin
          set_ovr = 1;
        end
      end
    end
    if (hs && !accepted) m_full = 0;
    m_ovr = set_ovr | (m_ovr & !clr);

    start = st; sen = se; sin = si; dir = di; out_ready = rdy; ovr_clr = clr;
    @(posedge clk);
    #1;
    check("busy", 32'(busy), 32'(m_busy));
    check("out_valid", 32'(out_valid), 32'(m_full));
    check("overrun", 32'(overrun), 32'(m_ovr));
    check("out", 32'(out), 32'(m_out));
  endtask

  // w is given in output orientation; bits go on the wire in the order dir implies.
  task automatic send(input bit d, input logic [W-1:0] w, input int gapmax, input int rdy_body,
                      input int rdy_last, input bit clr_rand, input bit clr_last);
    cycle(1, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), d, rnd_rdy(rdy_body), 0);
    for (int i = 0; i < int'(W); i++) begin
      bit b;
      int g;
      b = d ? w[i] : w[W-1-i];
      g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
      repeat (g) begin
        cycle(0, 0, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), rnd_rdy(rdy_body),
              clr_rand && ($urandom_range(0, 5) == 0));
      end
      if (i == int'(W) - 1) begin
        cycle(0, 1, b, bit'($urandom_range(0, 1)), rnd_rdy(rdy_last),
              clr_last || (clr_rand && ($urandom_range(0, 5) == 0)));
      end else begin
        cycle(0, 1, b, bit'($urandom_range(0, 1)), rnd_rdy(rdy_body),
              clr_rand && ($urandom_range(0, 5) == 0));
      end
    end
  endtask

  task automatic drain();
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b0;
    start = 0; sen = 0; sin = 0; dir = 0; out_ready = 0; ovr_clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", 32'(out), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    reset = 1'b1;

    // MSB-first, back-to-back bits, consumer stalled
    send(0, 4'b1011, 0, 0, 0, 0, 0);
    check("msb_out", 32'(out), 32'hB);
    check("msb_valid", 32'(out_valid), 32'h1);
    check("msb_busy", 32'(busy), 32'h0);
    drain();

    // LSB-first with strobe gaps: wire bits 1,0,1,1
    send(1, 4'b1101, 3, 0, 0, 0, 0);
    check("lsb_out", 32'(out), 32'hD);
    drain();

    // Overrun: second word dropped, then cleared, then set-wins over clear
    send(0, 4'b1011, 1, 0, 0, 0, 0);
    send(0, 4'b0110, 1, 0, 0, 0, 0);
    check("ovr_out", 32'(out), 32'hB);
    check("ovr_flag", 32'(overrun), 32'h1);
    cycle(0, 0, 0, 0, 0, 1);
    check("ovr_clr", 32'(overrun), 32'h0);
    send(1, 4'b0011, 0, 0, 0, 0, 1);
    check("ovr_setwins", 32'(overrun), 32'h1);
    cycle(0, 0, 0, 0, 0, 1);
    drain();

    // Completion coincides with handshake of the held word
    send(0, 4'b1011, 0, 0, 0, 0, 0);
    send(0, 4'b0110, 0, 0, 1, 0, 0);
    check("simul_out", 32'(out), 32'h6);
    check("simul_valid", 32'(out_valid), 32'h1);
    check("simul_ovr", 32'(overrun), 32'h0);
    drain();

    // Abort after two bits, then a clean MSB-first 1,1,0,0
    cycle(1, 0, 0, 1, 0, 0);
    cycle(0, 1, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    send(0, 4'b1100, 0, 0, 0, 0, 0);
    check("abort_out", 32'(out), 32'hC);

    // Asynchronous reset in the middle of a frame
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    start = 0; sen = 0;
    #2 reset = 1'b0;
    #1;
    check("arst_out", 32'(out), 32'h0);
    check("arst_valid", 32'(out_valid), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_overrun", 32'(overrun), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Idle noise with a word held in the buffer
    send(0, 4'b1001, 0, 0, 0, 0, 0);
    repeat (10) cycle(0, 1, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 0, 0);
    check("idle_out", 32'(out), 32'h9);
    check("idle_busy", 32'(busy), 32'h0);
    drain();

    // Random frames: random order, gaps, stalls, clears and occasional aborts
    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(0, 7) == 0) begin
        int k;
        k = int'($urandom_range(0, W - 1));
        cycle(1, 0, 0, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 0);
        repeat (k) cycle(0, 1, bit'($urandom_range(0, 1)), 0, bit'($urandom_range(0, 1)), 0);
      end
      send(bit'($urandom_range(0, 1)), W'($urandom), 2, 2, 2, 1, 0);
      repeat ($urandom_range(0, 2)) cycle(0, bit'($urandom_range(0, 1)),
                                          bit'($urandom_range(0, 1)), 0,
                                          bit'($urandom_range(0, 1)), 0);
    end
    drain();
    check("sb_empty", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
